// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_chk.sv
// Protocol and bookkeeping assertions for instr_fetch.
module instr_fetch_chk
  import instr_fetch_pkg::*;
#(
  parameter int OW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          imem_rvalid_i,
  input logic [OW-1:0] outstanding_i,
  input logic [OW-1:0] tag_count_i,
  input logic          tag_empty_i,
  input fetch_entry_t  tag_head_i
);

  a_resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (outstanding_i != {OW{1'b0}}));

  a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_i == tag_count_i);

  a_tag_entry_intact: assert property (@(posedge clk) disable iff (!rst_n)
    !tag_empty_i |-> (tag_head_i.instr == NOP_INSTR));

endmodule

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with synchronous clear.
// Push and pop may coincide when full (pop frees the slot) or empty (no bypass).
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t data_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  assign full_s    = (count_q == CW'(DEPTH));
  assign do_pop_s  = pop_i && (count_q != {CW{1'b0}});
  assign do_push_s = push_i && (!full_s || do_pop_s);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so no stale entry is ever presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push_s && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues imem reads at pc_i, buffers {pc, instr} for decode, flushes on redirect.
// Optional FETCH_PERF_CNT_EN adds saturating decode-stall and flush counters.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic        pc_advance_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = CW + 1;

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count_s;
  logic [OW-1:0] tag_count_s;
  logic [SW-1:0] occupancy_s;
  logic          req_s, grant_s, resp_s, drop_s, push_s, pop_s;
  logic          data_empty_s, tag_empty_s;
  fetch_entry_t  tag_in_s, tag_head_s, data_in_s, data_head_s;

  // Reserving a FIFO slot per in-flight read means memory never needs backpressure.
  assign occupancy_s = SW'(outstanding_q) + SW'(fifo_count_s);
  assign req_s       = rst_n && !flush_i
                       && (outstanding_q < OW'(MAX_OUTSTANDING))
                       && (occupancy_s < SW'(FIFO_DEPTH));
  assign grant_s     = req_s && imem_gnt_i;
  assign resp_s      = imem_rvalid_i;
  assign drop_s      = (discard_q != {OW{1'b0}});
  assign push_s      = resp_s && !drop_s && !flush_i;
  assign pop_s       = instr_valid_o && instr_ready_i;

  // In-flight and discard bookkeeping; a flush discards everything still in flight.
  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    case ({grant_s, resp_s})
      2'b10:   outstanding_d = outstanding_q + OW'(1'b1);
      2'b01:   outstanding_d = outstanding_q - OW'(1'b1);
      default: outstanding_d = outstanding_q;
    endcase
    if (flush_i) begin
      discard_d = outstanding_d;
    end else if (resp_s && drop_s) begin
      discard_d = discard_q - OW'(1'b1);
    end else begin
      discard_d = discard_q;
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= {OW{1'b0}};
      discard_q     <= {OW{1'b0}};
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign tag_in_s  = '{pc: pc_i, instr: NOP_INSTR};
  assign data_in_s = '{pc: tag_head_s.pc, instr: imem_rdata_i};

  fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (1'b0),
    .push_i  (grant_s),
    .data_i  (tag_in_s),
    .pop_i   (resp_s),
    .data_o  (tag_head_s),
    .empty_o (tag_empty_s),
    .count_o (tag_count_s)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_data_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush_i),
    .push_i  (push_s),
    .data_i  (data_in_s),
    .pop_i   (pop_s),
    .data_o  (data_head_s),
    .empty_o (data_empty_s),
    .count_o (fifo_count_s)
  );

  instr_fetch_chk #(.OW(OW)) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_rvalid_i (imem_rvalid_i),
    .outstanding_i (outstanding_q),
    .tag_count_i   (tag_count_s),
    .tag_empty_i   (tag_empty_s),
    .tag_head_i    (tag_head_s)
  );

  assign imem_req_o    = req_s;
  assign imem_addr_o   = pc_i;
  assign pc_advance_o  = grant_s;
  assign instr_valid_o = !data_empty_s;
  assign instr_o       = data_head_s.instr;
  assign instr_pc_o    = data_head_s.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      if (instr_valid_o && !instr_ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`else
  assign perf_stall_cnt_o = 32'h0000_0000;
  assign perf_flush_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with an in-order, fixed-latency memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        pc_advance_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_flush_cnt_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  bit pc_auto = 1'b1;
  logic [31:0] pend_a[$];
  int          pend_due[$];

  instr_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_i             (pc_i),
    .pc_advance_o     (pc_advance_o),
    .flush_i          (flush_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 10);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record this cycle's grant, advance, then drive memory response and PC.
  task automatic step();
    logic        g;
    logic [31:0] a;
    #1;
    g = pc_advance_o;
    a = imem_addr_o;
    @(posedge clk);
    #1;
    cyc++;
    if (g) begin
      pend_a.push_back(a);
      pend_due.push_back(cyc - 1 + lat);
    end
    if (g && pc_auto) pc_i = pc_i + 32'd4;
    if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_a[0]);
      void'(pend_a.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b1;
    pend_a.delete();
    pend_due.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    lat   = 1;
    pc_auto = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants;
    rst_n = 1'b1; pc_i = 32'h0; flush_i = 1'b0; imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; instr_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_req",   {31'd0, imem_req_o},    32'd0);
    check_eq("rst_adv",   {31'd0, pc_advance_o},  32'd0);
    check_eq("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check_eq("rst_instr", instr_o,    32'h0);
    check_eq("rst_ipc",   instr_pc_o, 32'h0);
    check_eq("rst_stall", perf_stall_cnt_o, 32'h0);
    check_eq("rst_flush", perf_flush_cnt_o, 32'h0);

    // 1: single fetch
    do_reset();
    pc_i = 32'h0; pc_auto = 1'b0;
    #1;
    check_eq("t1_adv", {31'd0, pc_advance_o}, 32'd1);
    check_eq("t1_addr", imem_addr_o, 32'h0);
    step();
    imem_gnt_i = 1'b0;
    #1;
    check_eq("t1_adv_once", {31'd0, pc_advance_o}, 32'd0);
    check_eq("t1_valid_early", {31'd0, instr_valid_o}, 32'd0);
    step();
    #1;
    check_eq("t1_valid", {31'd0, instr_valid_o}, 32'd1);
    check_eq("t1_instr", instr_o, 32'h0050_0093);
    check_eq("t1_ipc", instr_pc_o, 32'h0);
    step();
    #1;
    check_eq("t1_drained", {31'd0, instr_valid_o}, 32'd0);

    // 2: streaming, one instruction per cycle after fill
    do_reset();
    pc_i = 32'h0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_valid", {31'd0, instr_valid_o}, 32'd1);
      check_eq("t2_ipc", instr_pc_o, 32'(4 * i));
      check_eq("t2_instr", instr_o, mem_word(32'(4 * i)));
      check_eq("t2_adv", {31'd0, pc_advance_o}, 32'd1);
      step();
    end

    // 3: backpressure fills the buffer, then drains in order
    do_reset();
    pc_i = 32'h0; instr_ready_i = 1'b0; grants = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (pc_advance_o) grants++;
      step();
    end
    #1;
    check_eq("t3_grants", 32'(grants), 32'd4);
    check_eq("t3_req_full", {31'd0, imem_req_o}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("t3_stall_cnt", perf_stall_cnt_o, 32'd10);
`else
    check_eq("t3_stall_cnt", perf_stall_cnt_o, 32'd0);
`endif
    instr_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t3_valid", {31'd0, instr_valid_o}, 32'd1);
      check_eq("t3_ipc", instr_pc_o, 32'(4 * i));
      if (i == 1) check_eq("t3_resume", {31'd0, pc_advance_o}, 32'd1);
      step();
    end

    // 4: flush with one buffered and two in-flight reads
    do_reset();
    pc_i = 32'h0C; instr_ready_i = 1'b0;
    step();
    lat = 5;
    step();
    step();
    #1;
    check_eq("t4_buffered", instr_pc_o, 32'h0C);
    check_eq("t4_req_max", {31'd0, imem_req_o}, 32'd0);
    flush_i = 1'b1; pc_i = 32'h40; instr_ready_i = 1'b1;
    #1;
    check_eq("t4_req_flush", {31'd0, imem_req_o}, 32'd0);
    step();
    flush_i = 1'b0; lat = 1;
    #1;
    check_eq("t4_cleared", {31'd0, instr_valid_o}, 32'd0);
    for (int n = 0; n < 20; n++) begin
      #1;
      if (instr_valid_o) break;
      step();
    end
    check_eq("t4_valid", {31'd0, instr_valid_o}, 32'd1);
    check_eq("t4_first_pc", instr_pc_o, 32'h40);
    check_eq("t4_first_instr", instr_o, mem_word(32'h40));
`ifdef FETCH_PERF_CNT_EN
    check_eq("t4_flush_cnt", perf_flush_cnt_o, 32'd1);
`else
    check_eq("t4_flush_cnt", perf_flush_cnt_o, 32'd0);
`endif

    // 5: near-full buffer, pop and response push in the same cycle
    do_reset();
    pc_i = 32'h0; instr_ready_i = 1'b0;
    repeat (4) step();
    #1;
    check_eq("t5_req_reserved", {31'd0, imem_req_o}, 32'd0);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq("t5_valid", {31'd0, instr_valid_o}, 32'd1);
      check_eq("t5_ipc", instr_pc_o, 32'(4 * i));
      step();
    end

    // 6: asynchronous reset mid-stream
    do_reset();
    pc_i = 32'h0; lat = 2;
    repeat (3) step();
    #1;
    check_eq("t6_pre_valid", {31'd0, instr_valid_o}, 32'd1);
    rst_n = 1'b0;
    pend_a.delete(); pend_due.delete();
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    #1;
    check_eq("t6_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("t6_adv", {31'd0, pc_advance_o}, 32'd0);
    check_eq("t6_valid", {31'd0, instr_valid_o}, 32'd0);
    check_eq("t6_instr", instr_o, 32'h0);
    check_eq("t6_ipc", instr_pc_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; pc_i = 32'h80; lat = 1; cyc = 0;
    #1;
    check_eq("t6_addr", imem_addr_o, 32'h80);
    check_eq("t6_adv_rel", {31'd0, pc_advance_o}, 32'd1);
    step();
    #1;
    check_eq("t6_no_stale", {31'd0, instr_valid_o}, 32'd0);
    step();
    #1;
    check_eq("t6_valid_rel", {31'd0, instr_valid_o}, 32'd1);
    check_eq("t6_first_pc", instr_pc_o, 32'h80);
    check_eq("t6_first_instr", instr_o, mem_word(32'h80));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
